// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab3 bit-serial adder.
package lab3_pkg;
  localparam int LAB3_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/lab3_serial_fa_cell.sv
// 1-bit full adder; with LAB3_SUB_MODE_EN it also acts as a full subtractor
// (c_in = borrow-in, c_out = borrow-out when sub=1).
module lab3_serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
`ifdef LAB3_SUB_MODE_EN
  input  logic sub,
`endif
  output logic s,
  output logic c_out
);
  logic a_eff;

  // Borrow generation is the carry equation with the minuend bit inverted.
`ifdef LAB3_SUB_MODE_EN
  assign a_eff = sub ? ~a : a;
`else
  assign a_eff = a;
`endif

  assign s     = a ^ b ^ c_in;
  assign c_out = (a_eff & b) | (a_eff & c_in) | (b & c_in);
endmodule

// File: rtl/lab3_4_bit_serial_adder.sv
// Bit-serial S = X + Y + Cin, one bit per clock, LSB first.
// Define LAB3_SUB_MODE_EN to add the sub port (S = X - Y - Cin, Cout = borrow).
module lab3_4_bit_serial_adder
  import lab3_pkg::*;
#(
  parameter int WIDTH = LAB3_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
`ifdef LAB3_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic             fa_s, fa_c;
`ifdef LAB3_SUB_MODE_EN
  logic             sub_q, sub_d;
`endif

  lab3_serial_fa_cell u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (c_q),
`ifdef LAB3_SUB_MODE_EN
    .sub   (sub_q),
`endif
    .s     (fa_s),
    .c_out (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
`ifdef LAB3_SUB_MODE_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
`ifdef LAB3_SUB_MODE_EN
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
`ifdef LAB3_SUB_MODE_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = X;
          b_d     = Y;
          c_d     = Cin;
          cnt_d   = '0;
          s_d     = '0;
`ifdef LAB3_SUB_MODE_EN
          sub_d   = sub;
`endif
        end
      end
      SHIFT: begin
        c_d   = fa_c;
        s_d   = {fa_s, s_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // Last bit: Cout takes the final carry on the same edge as the MSB.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          cout_d  = fa_c;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
endmodule
